// File: rtl/seq_checker.sv
// Counter-sequence checker: acquires lock on an incrementing stream of
// 8..11-bit values and counts wraps and out-of-sequence errors.
module seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [10:0]      data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       wrap_count,
  output logic [10:0]      expected_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t      state;
  logic [1:0]  mode_q;
  logic        have_prev;
  logic        miss_q;
  logic [3:0]  match_cnt;
  logic [3:0]  match_inc;
  logic [10:0] mask;
  logic [10:0] sample;
  logic [10:0] next_exp;
  logic        go;
  logic        take;
  logic        hit;

  always_comb begin
    mask = 11'h0FF;
    unique case (mode_q)
      2'b00: mask = 11'h0FF;
      2'b01: mask = 11'h1FF;
      2'b10: mask = 11'h3FF;
      2'b11: mask = 11'h7FF;
    endcase
  end

  // expected_out doubles as the stored prev+1, so a match is a
  // direct compare against it
  assign sample    = data_in & mask;
  assign next_exp  = (sample + 11'd1) & mask;
  assign go        = start & ~stop;
  assign take      = data_valid & ~stop & ~go & (state != IDLE);
  assign hit       = have_prev & (sample == expected_out);
  assign match_inc = match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 2'b00;
      have_prev    <= 1'b0;
      miss_q       <= 1'b0;
      match_cnt    <= 4'd0;
      locked       <= 1'b0;
      error_pulse  <= 1'b0;
      err_count    <= '0;
      wrap_count   <= 8'd0;
      expected_out <= 11'd0;
    end else begin
      error_pulse <= 1'b0;
      if (go) begin
        state        <= ACQUIRE;
        mode_q       <= mode;
        have_prev    <= 1'b0;
        miss_q       <= 1'b0;
        match_cnt    <= 4'd0;
        locked       <= 1'b0;
        err_count    <= '0;
        wrap_count   <= 8'd0;
        expected_out <= 11'd0;
      end else if (take) begin
        have_prev    <= 1'b1;
        expected_out <= next_exp;
        if (hit && sample == 11'd0)
          wrap_count <= wrap_count + 8'd1;
        if (state == ACQUIRE) begin
          if (hit) begin
            match_cnt <= match_inc;
            if (match_inc == LOCK_N) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            match_cnt <= 4'd0;
          end
        end else if (hit) begin
          miss_q <= 1'b0;
        end else begin
          error_pulse <= 1'b1;
          if (err_count != ERR_MAX)
            err_count <= err_count + 1'b1;
          if (miss_q) begin
            state     <= ACQUIRE;
            locked    <= 1'b0;
            miss_q    <= 1'b0;
            match_cnt <= 4'd0;
          end else begin
            miss_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: lock, wrap, errors, stop, reset.
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [10:0] data_in;
  logic        data_valid;
  logic        locked;
  logic        error_pulse;
  logic [7:0]  err_count;
  logic [7:0]  wrap_count;
  logic [10:0] expected_out;

  int tests = 0;
  int fails = 0;

  seq_checker #(.LOCK_COUNT(4), .ERR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .mode(mode),
    .data_in(data_in),
    .data_valid(data_valid),
    .locked(locked),
    .error_pulse(error_pulse),
    .err_count(err_count),
    .wrap_count(wrap_count),
    .expected_out(expected_out)
  );

  always #5 clk = ~clk;

  // one clock with the given inputs; outputs are observed 1ns after the edge
  task automatic cyc(input logic r, input logic st, input logic sp,
                     input logic dv, input logic [10:0] d);
    rst = r; start = st; stop = sp; data_valid = dv; data_in = d;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; data_valid = 1'b0;
  endtask

  task automatic feed(input logic [10:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic arm(input logic [1:0] m);
    mode = m;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 11'd9);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked got %0d want 0", locked); end
    tests++; if (error_pulse !== 1'b0) begin fails++; $display("FAIL rst_pulse got %0d want 0", error_pulse); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rst_err got %0d want 0", err_count); end
    tests++; if (wrap_count !== 8'd0) begin fails++; $display("FAIL rst_wrap got %0d want 0", wrap_count); end
    tests++; if (expected_out !== 11'd0) begin fails++; $display("FAIL rst_exp got %0d want 0", expected_out); end
    feed(11'd7);
    feed(11'd8);
    tests++; if (expected_out !== 11'd0) begin fails++; $display("FAIL idle_exp got %0d want 0", expected_out); end
  endtask

  task automatic test_lock;
    arm(2'b00);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL arm_locked got %0d want 0", locked); end
    for (int i = 0; i < 4; i++) feed(11'(i));
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early got %0d want 0", locked); end
    tests++; if (expected_out !== 11'd4) begin fails++; $display("FAIL lock_exp3 got %0d want 4", expected_out); end
    feed(11'd4);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_on got %0d want 1", locked); end
    tests++; if (expected_out !== 11'd5) begin fails++; $display("FAIL lock_exp got %0d want 5", expected_out); end
  endtask

  task automatic test_wrap;
    arm(2'b00);
    for (int i = 249; i <= 253; i++) feed(11'(i));
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_lock got %0d want 1", locked); end
    feed(11'd254);
    feed(11'd255);
    tests++; if (expected_out !== 11'd0) begin fails++; $display("FAIL wrap_exp0 got %0d want 0", expected_out); end
    feed(11'd0);
    tests++; if (wrap_count !== 8'd1) begin fails++; $display("FAIL wrap_cnt0 got %0d want 1", wrap_count); end
    feed(11'd1);
    tests++; if (wrap_count !== 8'd1) begin fails++; $display("FAIL wrap_cnt got %0d want 1", wrap_count); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL wrap_err got %0d want 0", err_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked got %0d want 1", locked); end
    tests++; if (expected_out !== 11'd2) begin fails++; $display("FAIL wrap_exp got %0d want 2", expected_out); end
  endtask

  task automatic test_single_error;
    arm(2'b11);
    tests++; if (wrap_count !== 8'd0) begin fails++; $display("FAIL start_wrap got %0d want 0", wrap_count); end
    for (int i = 96; i <= 100; i++) feed(11'(i));
    feed(11'd105);
    tests++; if (error_pulse !== 1'b1) begin fails++; $display("FAIL se_pulse got %0d want 1", error_pulse); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL se_err1 got %0d want 1", err_count); end
    feed(11'd106);
    tests++; if (error_pulse !== 1'b0) begin fails++; $display("FAIL se_pulse_off got %0d want 0", error_pulse); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL se_err got %0d want 1", err_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL se_locked got %0d want 1", locked); end
    tests++; if (expected_out !== 11'd107) begin fails++; $display("FAIL se_exp got %0d want 107", expected_out); end
  endtask

  task automatic test_double_error;
    arm(2'b00);
    for (int i = 6; i <= 10; i++) feed(11'(i));
    feed(11'd50);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL de_lock1 got %0d want 1", locked); end
    feed(11'd70);
    tests++; if (error_pulse !== 1'b1) begin fails++; $display("FAIL de_pulse2 got %0d want 1", error_pulse); end
    tests++; if (err_count !== 8'd2) begin fails++; $display("FAIL de_err got %0d want 2", err_count); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL de_unlock got %0d want 0", locked); end
    tests++; if (expected_out !== 11'd71) begin fails++; $display("FAIL de_exp got %0d want 71", expected_out); end
    for (int i = 71; i <= 73; i++) feed(11'(i));
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL de_relock_early got %0d want 0", locked); end
    feed(11'd74);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL de_relock got %0d want 1", locked); end
  endtask

  task automatic test_stop;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 11'd999);
      tests++; if (locked !== 1'b1 || err_count !== 8'd2 || expected_out !== 11'd75 || error_pulse !== 1'b0) begin
        fails++; $display("FAIL stop_hold%0d got %0d/%0d/%0d/%0d want 1/2/75/0", i, locked, err_count, expected_out, error_pulse);
      end
    end
    mode = 2'b11;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    tests++; if (locked !== 1'b1 || err_count !== 8'd2) begin fails++; $display("FAIL stop_start got %0d/%0d want 1/2", locked, err_count); end
    feed(11'd75);
    feed(11'h44C);
    tests++; if (err_count !== 8'd2 || expected_out !== 11'd77) begin
      fails++; $display("FAIL mask_hold got %0d/%0d want 2/77", err_count, expected_out);
    end
  endtask

  task automatic test_rst_mid;
    feed(11'd200);
    feed(11'd201);
    tests++; if (err_count !== 8'd3 || locked !== 1'b1) begin fails++; $display("FAIL pre_rst got %0d/%0d want 3/1", err_count, locked); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 11'd202);
    tests++; if (locked !== 1'b0 || err_count !== 8'd0 || wrap_count !== 8'd0 || expected_out !== 11'd0 || error_pulse !== 1'b0) begin
      fails++; $display("FAIL mid_rst got %0d/%0d/%0d/%0d/%0d want 0", locked, err_count, wrap_count, expected_out, error_pulse);
    end
    for (int i = 202; i <= 207; i++) feed(11'(i));
    tests++; if (locked !== 1'b0 || expected_out !== 11'd0) begin fails++; $display("FAIL rst_idle got %0d/%0d want 0/0", locked, expected_out); end
    arm(2'b00);
    for (int i = 0; i <= 4; i++) feed(11'(i));
    tests++; if (locked !== 1'b1 || err_count !== 8'd0) begin fails++; $display("FAIL rst_relock got %0d/%0d want 1/0", locked, err_count); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    data_in = 11'd0; data_valid = 1'b0;
    test_reset;
    test_lock;
    test_wrap;
    test_single_error;
    test_double_error;
    test_stop;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
